// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the PC sequencer's control, flag, target and status signals.
// The clock and reset stay outside the interface as plain ports.
//   master : pipeline control side; drives controls, flags and target, observes status
//   slave  : the sequencer itself; the mirror image of master
// Signals:
//   in_stall, in_ctrl_jump, in_ctrl_branch, in_ctrl_btype[2:0], in_ctrl_call, in_ctrl_ret
//   in_flag_zero, in_flag_neg, in_flag_carry, in_flag_ovf, in_target[ADDR_W-1:0]
//   out_pc[ADDR_W-1:0], out_flush, out_ras_empty, out_ras_full, out_ras_err
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_stall;
  logic              in_ctrl_jump;
  logic              in_ctrl_branch;
  logic [2:0]        in_ctrl_btype;
  logic              in_ctrl_call;
  logic              in_ctrl_ret;
  logic              in_flag_zero;
  logic              in_flag_neg;
  logic              in_flag_carry;
  logic              in_flag_ovf;
  logic [ADDR_W-1:0] in_target;
  logic [ADDR_W-1:0] out_pc;
  logic              out_flush;
  logic              out_ras_empty;
  logic              out_ras_full;
  logic              out_ras_err;

  modport master (
    output in_stall, in_ctrl_jump, in_ctrl_branch, in_ctrl_btype, in_ctrl_call, in_ctrl_ret,
    output in_flag_zero, in_flag_neg, in_flag_carry, in_flag_ovf, in_target,
    input  out_pc, out_flush, out_ras_empty, out_ras_full, out_ras_err
  );

  modport slave (
    input  in_stall, in_ctrl_jump, in_ctrl_branch, in_ctrl_btype, in_ctrl_call, in_ctrl_ret,
    input  in_flag_zero, in_flag_neg, in_flag_carry, in_flag_ovf, in_target,
    output out_pc, out_flush, out_ras_empty, out_ras_full, out_ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered next-PC unit: owns the PC, evaluates branch conditions against the
// ALU flags, and handles jump/call/ret through a circular return-address stack.
// Ports:
//   in_clk    : system clock, rising edge
//   in_rst_n  : asynchronous active-low reset
//   bus       : pc_sequencer_if.slave (controls, flags, target in; pc, flush, RAS status out)
module pc_sequencer #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]    PC_INC    = ADDR_W'(1),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  pc_sequencer_if.slave   bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_next, pc_seq, ras_top;
  logic              flush_q, flush_next;
  logic              empty_q, full_q, err_q;
  logic [PTR_W-1:0]  sp_q, sp_next, sp_inc, sp_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic              push, pop, err_set, taken;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  // sp_q points at the slot the next push writes; the stack is circular so an
  // overflowing push simply overwrites the oldest entry.
  assign sp_inc  = (sp_q == PTR_LAST) ? '0 : sp_q + PTR_W'(1);
  assign sp_dec  = (sp_q == '0) ? PTR_LAST : sp_q - PTR_W'(1);
  assign ras_top = ras_mem[sp_dec];
  assign pc_seq  = pc_q + PC_INC;

  always_comb begin
    taken = 1'b0;
    case (bus.in_ctrl_btype)
      3'd0:    taken = bus.in_flag_zero;
      3'd1:    taken = bus.in_flag_neg;
      3'd2:    taken = !bus.in_flag_zero;
      3'd3:    taken = !bus.in_flag_neg && !bus.in_flag_zero;
      3'd4:    taken = bus.in_flag_carry;
      3'd5:    taken = bus.in_flag_ovf;
      3'd6:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next    = pc_seq;
    flush_next = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    if (bus.in_stall) begin
      pc_next = pc_q;
    end else if (bus.in_ctrl_ret) begin
      if (cnt_q != '0) begin
        pc_next    = ras_top;
        pop        = 1'b1;
        flush_next = 1'b1;
      end else begin
        err_set = 1'b1;   // underflow: fall through to sequential PC
      end
    end else if (bus.in_ctrl_call) begin
      pc_next    = bus.in_target;
      push       = 1'b1;
      flush_next = 1'b1;
      err_set    = (cnt_q == CNT_MAX);
    end else if (bus.in_ctrl_jump) begin
      pc_next    = bus.in_target;
      flush_next = 1'b1;
    end else if (bus.in_ctrl_branch && taken) begin
      pc_next    = bus.in_target;
      flush_next = 1'b1;
    end
  end

  always_comb begin
    cnt_next = cnt_q;
    sp_next  = sp_q;
    if (push) begin
      sp_next = sp_inc;
      if (cnt_q != CNT_MAX) cnt_next = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_next  = sp_dec;
      cnt_next = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      flush_q <= flush_next;
      sp_q    <= sp_next;
      cnt_q   <= cnt_next;
      empty_q <= (cnt_next == '0);
      full_q  <= (cnt_next == CNT_MAX);
      if (err_set) err_q <= 1'b1;
    end
  end

  // Entries need no reset: a zero count makes stale contents unreachable.
  always_ff @(posedge in_clk) begin
    if (push) ras_mem[sp_q] <= pc_seq;
  end

  assign bus.out_pc        = pc_q;
  assign bus.out_flush     = flush_q;
  assign bus.out_ras_empty = empty_q;
  assign bus.out_ras_full  = full_q;
  assign bus.out_ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Scoreboard bench: each stimulus step pushes the reference model's expected
// outputs; a monitor pops and compares one entry per clock after the edge.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W(32), .RESET_PC(RST_PC), .PC_INC(32'd1), .RAS_DEPTH(DEPTH)
  ) dut (
    .in_clk(clk), .in_rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_err;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond(input logic [2:0] bt, input logic [3:0] fl);
    logic z, n, c, v;
    {z, n, c, v} = fl;
    case (bt)
      3'd0: return z;
      3'd1: return n;
      3'd2: return !z;
      3'd3: return !n && !z;
      3'd4: return c;
      3'd5: return v;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  // fl = {zero, neg, carry, ovf}
  task automatic step(input logic st, jp, br, input logic [2:0] bt,
                      input logic cl, rt, input logic [3:0] fl, input logic [31:0] tg);
    exp_t e;
    logic redir;
    bus.in_stall = st; bus.in_ctrl_jump = jp; bus.in_ctrl_branch = br;
    bus.in_ctrl_btype = bt; bus.in_ctrl_call = cl; bus.in_ctrl_ret = rt;
    {bus.in_flag_zero, bus.in_flag_neg, bus.in_flag_carry, bus.in_flag_ovf} = fl;
    bus.in_target = tg;
    redir = 1'b0;
    if (st) begin
      // everything frozen
    end else if (rt) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        redir = 1'b1;
      end else begin
        m_pc = m_pc + 32'd1;
        m_err = 1'b1;
      end
    end else if (cl) begin
      m_ras.push_back(m_pc + 32'd1);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
      m_pc = tg;
      redir = 1'b1;
    end else if (jp || (br && cond(bt, fl))) begin
      m_pc = tg;
      redir = 1'b1;
    end else begin
      m_pc = m_pc + 32'd1;
    end
    e.pc = m_pc; e.flush = redir; e.empty = (m_ras.size() == 0);
    e.full = (m_ras.size() == DEPTH); e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 0, 0, 4'h0, 32'h0);
  endtask
  task automatic jump(input logic [31:0] t);
    step(0, 1, 0, 3'd0, 0, 0, 4'h0, t);
  endtask
  task automatic call(input logic [31:0] t);
    step(0, 0, 0, 3'd0, 1, 0, 4'h0, t);
  endtask
  task automatic ret();
    step(0, 0, 0, 3'd0, 0, 1, 4'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc", bus.out_pc, e.pc);
        chk("sb_flush", 32'(bus.out_flush), 32'(e.flush));
        chk("sb_empty", 32'(bus.out_ras_empty), 32'(e.empty));
        chk("sb_full", 32'(bus.out_ras_full), 32'(e.full));
        chk("sb_err", 32'(bus.out_ras_err), 32'(e.err));
      end
    end
  end

  initial begin : stim
    bus.in_stall = 0; bus.in_ctrl_jump = 0; bus.in_ctrl_branch = 0; bus.in_ctrl_btype = 0;
    bus.in_ctrl_call = 0; bus.in_ctrl_ret = 0; bus.in_flag_zero = 0; bus.in_flag_neg = 0;
    bus.in_flag_carry = 0; bus.in_flag_ovf = 0; bus.in_target = 0;
    model_reset();
    #12;
    chk("rst_pc", bus.out_pc, RST_PC);
    chk("rst_flush", 32'(bus.out_flush), 32'd0);
    chk("rst_empty", 32'(bus.out_ras_empty), 32'd1);
    chk("rst_full", 32'(bus.out_ras_full), 32'd0);
    chk("rst_err", 32'(bus.out_ras_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("seq_pc", bus.out_pc, RST_PC + 32'(i));
    end

    for (int b = 0; b < 8; b++) begin
      step(0, 0, 1, 3'(b), 0, 0, 4'b1000, 32'h40);
      chk("btype_flush", 32'(bus.out_flush), (b == 0 || b == 6) ? 32'd1 : 32'd0);
    end

    jump(32'h10);
    call(32'h80);  chk("call1_pc", bus.out_pc, 32'h80);
    call(32'hC0);  chk("call2_pc", bus.out_pc, 32'hC0);
    ret();         chk("ret1_pc", bus.out_pc, 32'h81);
    ret();         chk("ret2_pc", bus.out_pc, 32'h11);
    chk("nest_empty", 32'(bus.out_ras_empty), 32'd1);
    chk("nest_err", 32'(bus.out_ras_err), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      call(32'h200 + 32'(i) * 32'h100);
      if (i == 4) chk("ovf_full4", 32'(bus.out_ras_full), 32'd1);
      if (i == 5) chk("ovf_err5", 32'(bus.out_ras_err), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      ret();
      chk("ovf_ret_pc", bus.out_pc, 32'h601 - 32'(i) * 32'h100);
    end
    ret();
    chk("udf_pc", bus.out_pc, 32'h302);
    chk("udf_flush", 32'(bus.out_flush), 32'd0);

    call(32'h900);
    step(0, 1, 0, 3'd0, 1, 1, 4'h0, 32'hA00);
    chk("prio_pc", bus.out_pc, 32'h303);
    chk("prio_empty", 32'(bus.out_ras_empty), 32'd1);
    step(1, 1, 0, 3'd0, 0, 0, 4'h0, 32'hB00);
    chk("stall_pc", bus.out_pc, 32'h303);
    chk("stall_flush", 32'(bus.out_flush), 32'd0);

    jump(32'hFFFF_FFFF);
    idle();
    chk("wrap_pc", bus.out_pc, 32'h0);
    call(32'h20);
    call(32'h30);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", bus.out_pc, RST_PC);
    chk("arst_empty", 32'(bus.out_ras_empty), 32'd1);
    chk("arst_err", 32'(bus.out_ras_err), 32'd0);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[2:0] == 3'd0, r[5:3] == 3'd0, r[6], r[9:7], r[12:10] == 3'd0,
           r[15:13] < 3'd2, r[19:16], $urandom);
    end

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
